// File: rtl/mem_req_arbiter_if.sv
// Bus bundle for mem_req_arbiter: both core request ports and the single
// downstream dcache_mem_* port.
//   m0_* / m1_*  : core request (addr, wdata, be, we, req) and response
//                  (rdata, ready)
//   mem_*        : merged request toward memory (addr, wdata, be, we, req)
//                  and its response (rdata, ready)
// Modports:
//   slave  - the arbiter: consumes core requests and memory responses,
//            produces core responses and the memory request
//   master - the environment (cores + memory), the mirror image
interface mem_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m0_addr;
  logic [DATA_WIDTH-1:0]   m0_wdata;
  logic [DATA_WIDTH/8-1:0] m0_be;
  logic                    m0_we;
  logic                    m0_req;
  logic [DATA_WIDTH-1:0]   m0_rdata;
  logic                    m0_ready;

  logic [ADDR_WIDTH-1:0]   m1_addr;
  logic [DATA_WIDTH-1:0]   m1_wdata;
  logic [DATA_WIDTH/8-1:0] m1_be;
  logic                    m1_we;
  logic                    m1_req;
  logic [DATA_WIDTH-1:0]   m1_rdata;
  logic                    m1_ready;

  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_we;
  logic                    mem_req;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ready;

  modport slave (
    input  m0_addr, m0_wdata, m0_be, m0_we, m0_req,
    input  m1_addr, m1_wdata, m1_be, m1_we, m1_req,
    input  mem_rdata, mem_ready,
    output m0_rdata, m0_ready, m1_rdata, m1_ready,
    output mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );

  modport master (
    output m0_addr, m0_wdata, m0_be, m0_we, m0_req,
    output m1_addr, m1_wdata, m1_be, m1_we, m1_req,
    output mem_rdata, mem_ready,
    input  m0_rdata, m0_ready, m1_rdata, m1_ready,
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-master round-robin arbiter in front of the D-cache memory port.
// A winning request is latched and held on mem_* until the memory's
// one-cycle ready pulse, which is routed back to the winner only.
// mem_req drops for the DONE cycle between transactions.
// Ports:
//   clk  - system clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - mem_req_arbiter_if.slave (core request/response ports and the
//          merged memory port)
module mem_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mem_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic                    grant;
  logic                    last_grant;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic                    we_q;

  logic                    pick_m1;
  logic                    busy;

  // Under contention the master that did not win last time goes next.
  always_comb begin
    pick_m1 = 1'b0;
    if (bus.m0_req && bus.m1_req) pick_m1 = ~last_grant;
    else                          pick_m1 = bus.m1_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            grant      <= pick_m1;
            last_grant <= pick_m1;
            addr_q     <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
            wdata_q    <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
            be_q       <= pick_m1 ? bus.m1_be    : bus.m0_be;
            we_q       <= pick_m1 ? bus.m1_we    : bus.m0_we;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);

  // Memory-side fields are forced to zero outside BUSY so nothing stale
  // (in particular a write enable) can leak onto the port.
  assign bus.mem_req   = busy;
  assign bus.mem_addr  = busy ? addr_q  : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;
  assign bus.mem_be    = busy ? be_q    : '0;
  assign bus.mem_we    = busy & we_q;

  // Ready is combinational from mem_ready, qualified by BUSY so a stray
  // pulse in any other state is ignored.
  assign bus.m0_ready = busy & bus.mem_ready & ~grant;
  assign bus.m1_ready = busy & bus.mem_ready &  grant;

  assign bus.m0_rdata = bus.mem_rdata;
  assign bus.m1_rdata = bus.mem_rdata;
endmodule
